// File: rtl/btn_conditioner.sv
// Front-panel switch conditioner: synchronise, debounce, edge-detect and auto-repeat.
// Define BTN_AUTOREPEAT_EN to build the hold-to-repeat timers on the inc/dec channels.

module btn_debounce #(
    parameter int unsigned DEB_CNT = 10
) (
    input  logic clk_500,
    input  logic rst,
    input  logic raw,
    input  logic level,
    output logic level_nxt
);
    localparam int unsigned   CW       = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk_500) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
            cnt_q  <= cnt_d;
        end
    end

    // The level register sits in the parent so pulse logic can act on the toggling edge.
    always_comb begin
        level_nxt = level;
        cnt_d     = cnt_q + 1'b1;
        if (sync_q[1] == level) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_nxt = ~level;
            cnt_d     = '0;
        end
    end
endmodule

module btn_repeat
`ifdef BTN_AUTOREPEAT_EN
#(
    parameter int unsigned RPT_DLY = 250,
    parameter int unsigned RPT_PER = 50
)
`endif
(
    input  logic clk_500,
    input  logic rst,
    input  logic level,
    input  logic level_nxt,
    input  logic inhibit,
    output logic pulse
);
    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   pulse_d;
    logic   held;
    logic   rise;

    assign held = level_nxt & ~inhibit;
    assign rise = held & ~level;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned   TMAX_CYC = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int unsigned   TW       = $clog2(TMAX_CYC + 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(RPT_DLY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(RPT_PER - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [TW-1:0] timer_inc;

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk_500) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse   <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = DELAY;
            end
            DELAY: begin
                if (!held)                    state_d = IDLE;
                else if (timer_q == DLY_LAST) state_d = REPEAT;
                else                          timer_d = timer_inc;
            end
            REPEAT: begin
                if (!held)                    state_d = IDLE;
                else if (timer_q != PER_LAST) timer_d = timer_inc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pulse_d = 1'b0;
        case (state_q)
            IDLE:    pulse_d = rise;
            DELAY:   pulse_d = held && (timer_q == DLY_LAST);
            REPEAT:  pulse_d = held && (timer_q == PER_LAST);
            default: pulse_d = 1'b0;
        endcase
    end
`else
    always_ff @(posedge clk_500) begin
        if (rst) begin
            state_q <= IDLE;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse   <= pulse_d;
        end
    end

    // Without timers DELAY simply waits for release; REPEAT is never entered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise) state_d = DELAY;
            end
            DELAY: begin
                if (!held) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pulse_d = (state_q == IDLE) && rise;
    end
`endif
endmodule

module btn_conditioner #(
    parameter int unsigned DEB_CNT = 10,
    parameter int unsigned RPT_DLY = 250,
    parameter int unsigned RPT_PER = 50
) (
    input  logic clk_500,
    input  logic rst,
    input  logic raw_cont,
    input  logic raw_step,
    input  logic raw_inc,
    input  logic raw_dec,
    output logic cont,
    output logic step,
    output logic step_pulse,
    output logic inc_pulse,
    output logic dec_pulse
);
    if (DEB_CNT < 1 || RPT_DLY < 1 || RPT_PER < 1) begin : g_bad_param
        $error("btn_conditioner: DEB_CNT, RPT_DLY and RPT_PER must all be at least 1");
    end

    logic cont_nxt;
    logic step_nxt;
    logic inc_lvl;
    logic inc_nxt;
    logic dec_lvl;
    logic dec_nxt;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_cont (
        .clk_500   (clk_500),
        .rst       (rst),
        .raw       (raw_cont),
        .level     (cont),
        .level_nxt (cont_nxt)
    );

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_step (
        .clk_500   (clk_500),
        .rst       (rst),
        .raw       (raw_step),
        .level     (step),
        .level_nxt (step_nxt)
    );

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_inc (
        .clk_500   (clk_500),
        .rst       (rst),
        .raw       (raw_inc),
        .level     (inc_lvl),
        .level_nxt (inc_nxt)
    );

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_dec (
        .clk_500   (clk_500),
        .rst       (rst),
        .raw       (raw_dec),
        .level     (dec_lvl),
        .level_nxt (dec_nxt)
    );

    always_ff @(posedge clk_500) begin
        if (rst) begin
            cont       <= 1'b0;
            step       <= 1'b0;
            inc_lvl    <= 1'b0;
            dec_lvl    <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            cont       <= cont_nxt;
            step       <= step_nxt;
            inc_lvl    <= inc_nxt;
            dec_lvl    <= dec_nxt;
            step_pulse <= step_nxt & ~step;
        end
    end

    btn_repeat
`ifdef BTN_AUTOREPEAT_EN
        #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER))
`endif
        u_rpt_inc (
        .clk_500   (clk_500),
        .rst       (rst),
        .level     (inc_lvl),
        .level_nxt (inc_nxt),
        .inhibit   (1'b0),
        .pulse     (inc_pulse)
    );

    // inc wins when both are held: dec is kept idle and must see a fresh press.
    btn_repeat
`ifdef BTN_AUTOREPEAT_EN
        #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER))
`endif
        u_rpt_dec (
        .clk_500   (clk_500),
        .rst       (rst),
        .level     (dec_lvl),
        .level_nxt (dec_nxt),
        .inhibit   (inc_nxt),
        .pulse     (dec_pulse)
    );
endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEB_CNT, default 10: consecutive stable cycles required to accept a new button level.
REQ-002 Parameter RPT_DLY, default 250: hold cycles after the press pulse before the first auto-repeat pulse.
REQ-003 Parameter RPT_PER, default 50: cycles between successive auto-repeat pulses.
REQ-004 clk_500  in  1  Sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  Reset; synchronous, active-high.
REQ-006 raw_cont  in  1  Run/step mode switch, asynchronous to clk_500.
REQ-007 raw_step, raw_inc, raw_dec  in  1 each  Push buttons, asynchronous and bouncing.
REQ-008 cont  out  1  Synchronised, debounced mode switch level.
REQ-009 step  out  1  Debounced step button level, used downstream as the manual CPU clock.
REQ-010 step_pulse  out  1  One-cycle pulse on each debounced rising edge of step.
REQ-011 inc_pulse, dec_pulse  out  1 each  One-cycle address-increment and address-decrement strobes for the debug display unit.

Function
REQ-012 Each raw input SHALL pass through its own two-flop synchroniser before any other logic uses it.
REQ-013 Each channel SHALL hold a debounced level and a counter of width clog2(DEB_CNT+1); the counter clears on any cycle where the synchronised level equals the debounced level and otherwise increments.
REQ-014 The debounced level SHALL toggle, and the counter SHALL clear, on the edge where the counter would reach DEB_CNT. A raw level held stable therefore appears at the debounced output DEB_CNT+2 cycles after the first sampling edge.
REQ-015 Any bounce shorter than DEB_CNT cycles SHALL leave the debounced level and all outputs unchanged.
REQ-016 cont and step SHALL equal their debounced levels directly.
REQ-017 step_pulse SHALL be high for exactly the one cycle in which debounced step goes from 0 to 1.
REQ-018 The inc and dec channels SHALL each run an FSM with states IDLE, DELAY and REPEAT, using one shared-width timer per channel of width clog2(max(RPT_DLY,RPT_PER)+1).
REQ-019 IDLE -> DELAY: on a debounced rising edge the FSM SHALL emit one pulse in that cycle and load the timer with 0.
REQ-020 DELAY -> REPEAT: when the timer reaches RPT_DLY-1 while the button is held, the FSM SHALL emit one pulse and clear the timer.
REQ-021 REPEAT: when the timer reaches RPT_PER-1 while the button is held, the FSM SHALL emit one pulse and clear the timer; otherwise the timer increments.
REQ-022 From DELAY or REPEAT, the FSM SHALL return to IDLE with no pulse in the cycle the debounced level falls, and the timer SHALL clear.
REQ-023 If debounced inc and debounced dec are both 1 in a cycle, dec_pulse SHALL be forced to 0 and the dec FSM held in IDLE, while inc behaves normally. When inc is later released, dec needs a fresh rising edge to pulse.
REQ-024 Timers SHALL saturate and never wrap; no pulse SHALL be generated by wrap-around.
REQ-025 inc_pulse and dec_pulse SHALL be registered outputs, with no combinational path from any raw input.

Reset
REQ-026 While rst=1 at a clock edge, all synchronisers, debounced levels, counters and timers SHALL clear to 0, all FSMs SHALL enter IDLE, and all outputs SHALL be 0 from the next cycle.
REQ-027 Reset SHALL take priority over every other event, including a pulse due in the same cycle.
REQ-028 A button held through reset release SHALL be treated as a new press: the debounced level rises DEB_CNT+2 cycles after release and the press pulse is emitted in that cycle.

Configuration
REQ-029 Macro BTN_AUTOREPEAT_EN defined: the DELAY/REPEAT behaviour in REQ-020 and REQ-021 SHALL be present.
REQ-030 Macro BTN_AUTOREPEAT_EN undefined: no timers SHALL be synthesised, and each press SHALL produce exactly one pulse regardless of hold time, with the FSM waiting in DELAY until release.

Verification (defaults, BTN_AUTOREPEAT_EN defined)
REQ-031 raw_inc toggles every 3 cycles for 40 cycles, then settles at 0 -> inc_pulse stays 0 throughout.
REQ-032 raw_inc rises at cycle 0 and is held 100 cycles -> exactly one inc_pulse, at cycle 12.
REQ-033 raw_dec held 400 cycles from cycle 0 -> dec_pulse at cycles 12, 262, 312 and 362 only.
REQ-034 raw_inc and raw_dec rise together and are held 300 cycles -> inc_pulse at 12 and 262; dec_pulse never asserts.
REQ-035 raw_step held from cycle 0, rst pulsed at cycle 20 for one cycle -> step_pulse at 12, step=0 at cycle 21, then step_pulse again at cycle 33.
REQ-036 BTN_AUTOREPEAT_EN undefined, raw_inc held 500 cycles -> a single inc_pulse, at cycle 12.
